// File: rtl/routing_config_loader.sv
// Serial configuration loader: accepts words over valid/ready and shifts them LSB first
// onto the routing fabric's config chain, pulsing cfg_commit after exactly CHAIN_LEN bits.
module routing_config_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              shift_en,
  output logic              shift_out,
  output logic              cfg_commit,
  output logic              busy,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int LEFT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  state_t              state, state_n;
  logic [WORD_W-1:0]   word, word_n;
  logic [LEFT_W-1:0]   bits_left, bits_left_n;
  logic [CNT_W-1:0]    bit_count_n;
  logic                cfg_ready_n, shift_en_n, shift_out_n, cfg_commit_n, busy_n;
  logic [31:0]         remain;
  logic [LEFT_W-1:0]   take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word       <= '0;
      bits_left  <= '0;
      bit_count  <= '0;
      cfg_ready  <= 1'b0;
      shift_en   <= 1'b0;
      shift_out  <= 1'b0;
      cfg_commit <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      word       <= word_n;
      bits_left  <= bits_left_n;
      bit_count  <= bit_count_n;
      cfg_ready  <= cfg_ready_n;
      shift_en   <= shift_en_n;
      shift_out  <= shift_out_n;
      cfg_commit <= cfg_commit_n;
      busy       <= busy_n;
    end
  end

  // Bits still owed to the chain, clipped to one word; only the final word can be partial.
  always_comb begin
    remain = 32'(CHAIN_LEN) - 32'(bit_count);
    take   = (remain < 32'(WORD_W)) ? LEFT_W'(remain) : LEFT_W'(WORD_W);
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_n      = state;
    word_n       = word;
    bits_left_n  = bits_left;
    bit_count_n  = bit_count;
    cfg_ready_n  = 1'b0;
    shift_en_n   = 1'b0;
    shift_out_n  = 1'b0;
    cfg_commit_n = 1'b0;
    busy_n       = busy;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n     = LOAD;
          bit_count_n = '0;
          busy_n      = 1'b1;
          cfg_ready_n = 1'b1;
        end
      end
      LOAD: begin
        cfg_ready_n = 1'b1;
        if (cfg_valid && cfg_ready) begin
          state_n     = SHIFT;
          cfg_ready_n = 1'b0;
          shift_en_n  = 1'b1;
          shift_out_n = cfg_data[0];
          word_n      = cfg_data >> 1;
          bits_left_n = take;
        end
      end
      SHIFT: begin
        bit_count_n = bit_count + 1'b1;
        bits_left_n = bits_left - 1'b1;
        if (bits_left == LEFT_W'(1)) begin
          if (bit_count == CNT_W'(CHAIN_LEN - 1)) begin
            state_n      = COMMIT;
            cfg_commit_n = 1'b1;
          end else begin
            state_n     = LOAD;
            cfg_ready_n = 1'b1;
          end
        end else begin
          shift_en_n  = 1'b1;
          shift_out_n = word[0];
          word_n      = word >> 1;
        end
      end
      COMMIT: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_routing_config_loader.sv
// Bench for routing_config_loader: two instances (16-bit and 12-bit chains, 8-bit words)
// checked every cycle against a bit-stream reference model, directed then randomized.
module tb_routing_config_loader;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] st, vld, rdy, se, so, cm, bz;
  logic [7:0] dat [2];
  logic [4:0] bc0;
  logic [3:0] bc1;

  always #5 clk = ~clk;

  routing_config_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .cfg_data(dat[0]), .cfg_valid(vld[0]),
    .cfg_ready(rdy[0]), .shift_en(se[0]), .shift_out(so[0]), .cfg_commit(cm[0]),
    .busy(bz[0]), .bit_count(bc0));

  routing_config_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .cfg_data(dat[1]), .cfg_valid(vld[1]),
    .cfg_ready(rdy[1]), .shift_en(se[1]), .shift_out(so[1]), .cfg_commit(cm[1]),
    .busy(bz[1]), .bit_count(bc1));

  int checks = 0;
  int failures = 0;

  // Reference model: a load is a bit stream cut from the accepted words.
  int         chain [2];
  int         m_pos [2], m_left [2];
  bit         m_busy [2], m_wait [2], m_commit [2];
  logic [7:0] m_words [2][2];
  // Directed words, valid gaps, latency and captured-sequence expectations.
  logic [7:0] dw [2][2];
  int         dn [2], di [2], gap [2];
  int         lat [2], lat_exp [2];
  bit         lat_run [2], cap_on [2], rnd;
  logic [15:0] cap [2], cap_exp [2];
  int         dut_commits [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      if (gap[d] > 0 && m_wait[d] && m_pos[d] > 0) begin
        vld[d] = 1'b0;
        gap[d]--;
      end else if (rnd) vld[d] = ($urandom_range(0, 3) != 0);
      else vld[d] = 1'b1;
      dat[d] = (di[d] < dn[d]) ? dw[d][di[d]] : 8'($urandom);
      if (rnd) st[d] = ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 0; m_wait[d] = 0; m_commit[d] = 0; m_pos[d] = 0; m_left[d] = 0;
        lat_run[d] = 0;
      end else if (m_commit[d]) begin
        m_commit[d] = 0; m_busy[d] = 0;
      end else if (m_left[d] > 0) begin
        m_pos[d]++; m_left[d]--;
        if (m_left[d] == 0) begin
          if (m_pos[d] == chain[d]) m_commit[d] = 1;
          else m_wait[d] = 1;
        end
      end else if (m_wait[d]) begin
        if (vld[d]) begin
          m_words[d][m_pos[d] / W] = dat[d];
          m_left[d] = chain[d] - m_pos[d];
          if (m_left[d] > W) m_left[d] = W;
          m_wait[d] = 0;
          if (di[d] < dn[d]) di[d]++;
        end
      end else if (!m_busy[d] && st[d]) begin
        m_busy[d] = 1; m_wait[d] = 1; m_pos[d] = 0;
        lat_run[d] = 1; lat[d] = 1; cap[d] = '0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] w;
    for (int d = 0; d < 2; d++) begin
      if (lat_run[d]) lat[d]++;
      if (cm[d] === 1'b1) dut_commits[d]++;
      check($sformatf("d%0d_ready", d), 32'(rdy[d]), 32'(m_wait[d]));
      check($sformatf("d%0d_shift_en", d), 32'(se[d]), 32'(m_left[d] > 0));
      check($sformatf("d%0d_commit", d), 32'(cm[d]), 32'(m_commit[d]));
      check($sformatf("d%0d_busy", d), 32'(bz[d]), 32'(m_busy[d]));
      check($sformatf("d%0d_bit_count", d), d == 0 ? 32'(bc0) : 32'(bc1), 32'(m_pos[d]));
      if (m_left[d] > 0) begin
        w = m_words[d][m_pos[d] / W];
        check($sformatf("d%0d_shift_out", d), 32'(so[d]), 32'(w[m_pos[d] % W]));
        cap[d][m_pos[d]] = so[d];
      end
      if (m_commit[d]) begin
        if (lat_exp[d] != 0) check($sformatf("d%0d_latency", d), 32'(lat[d]), 32'(lat_exp[d]));
        if (cap_on[d]) check($sformatf("d%0d_sequence", d), 32'(cap[d]), 32'(cap_exp[d]));
        lat_exp[d] = 0; cap_on[d] = 0; lat_run[d] = 0;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_until_idle(input bit poke);
    for (int i = 0; i < 200; i++) begin
      if (!m_busy[0] && !m_busy[1]) return;
      if (poke) st[0] = (m_left[0] > 0 && m_pos[0] % 3 == 1) || m_commit[0];
      drive();
      tick();
    end
    check("idle_timeout", 32'(bz), 32'(0));
  endtask

  task automatic directed_load(input int gap0);
    dw[0][0] = 8'hA5; dw[0][1] = 8'h3C;
    dw[1][0] = 8'h0F; dw[1][1] = 8'hF6;
    dn = '{2, 2}; di = '{0, 0};
    gap[0] = gap0;
    lat_exp[0] = 16 + 2 + 2 + gap0; lat_exp[1] = 12 + 2 + 2;
    cap_exp[0] = 16'h3CA5; cap_exp[1] = 16'h060F;
    cap_on = '{1, 1};
    st = 2'b11;
    drive();
    tick();
    st = 2'b00;
    run_until_idle(1'b0);
  endtask

  initial begin
    int c0;
    chain = '{16, 12};
    m_pos = '{0, 0}; m_left = '{0, 0};
    m_busy = '{0, 0}; m_wait = '{0, 0}; m_commit = '{0, 0};
    dn = '{0, 0}; di = '{0, 0}; gap = '{0, 0};
    lat = '{0, 0}; lat_exp = '{0, 0}; lat_run = '{0, 0}; cap_on = '{0, 0};
    dut_commits = '{0, 0};
    rnd = 0;
    dat[0] = 8'hFF; dat[1] = 8'hFF;

    // Reset held two cycles with start and valid high.
    @(negedge clk);
    rst = 1'b1; st = 2'b11; vld = 2'b11;
    tick();
    tick();
    rst = 1'b0; st = 2'b00;
    tick();

    directed_load(0);
    directed_load(5);

    // start pulses mid-SHIFT and during COMMIT must not restart the load.
    c0 = dut_commits[0];
    dn = '{0, 0}; di = '{0, 0};
    st = 2'b01;
    drive();
    tick();
    st = 2'b00;
    run_until_idle(1'b1);
    st = 2'b00;
    tick();
    tick();
    check("single_commit", 32'(dut_commits[0] - c0), 32'(1));

    // Reset after 5 bits shifted, then a clean full load.
    c0 = dut_commits[0];
    st = 2'b11;
    drive();
    tick();
    st = 2'b00;
    for (int i = 0; i < 50 && m_pos[0] != 5; i++) begin
      drive();
      tick();
    end
    check("reached_5_bits", d_bc0(), 32'(5));
    rst = 1'b1;
    drive();
    tick();
    rst = 1'b0;
    check("rst_shift_en", 32'(se[0]), 32'(0));
    check("rst_no_commit", 32'(dut_commits[0] - c0), 32'(0));
    directed_load(0);

    // Randomized valid, data, start and occasional reset.
    dn = '{0, 0}; di = '{0, 0};
    rnd = 1;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive();
      tick();
    end
    rst = 1'b0;
    rnd = 0;
    st = 2'b00;
    run_until_idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [31:0] d_bc0();
    return 32'(bc0);
  endfunction

endmodule
